// File: rtl/bcd_serial_adder.sv
// -----------------------------------------------------------------------------
// bcd_serial_adder
//
// Purpose:
//   Adds (or optionally subtracts) two DIGITS-digit packed-BCD operands one
//   digit per clock, least-significant digit first, through a single 4-bit
//   decimal-corrected adder slice. Operands come in and results go out over
//   valid/ready handshakes. Only one operation is in flight at a time.
//
// Configuration macro:
//   BCD_SUB_EN - when defined, `sub`=1 selects A - B - cin using 10's
//                complement and `cout` becomes the borrow-out. When
//                undefined, `sub` is ignored and the block always adds.
//
// Parameters:
//   DIGITS     - number of BCD digits per operand (1..16), default 4.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands and mode present
//   in_ready   out  block can accept operands (high only in IDLE)
//   a, b       in   packed BCD operands, digit 0 in bits [3:0]
//   cin        in   carry-in (add) / borrow-in (subtract)
//   sub        in   1 = A - B - cin, 0 = A + B + cin
//   out_valid  out  result valid (high only in DONE)
//   out_ready  in   consumer accepts the result
//   sum        out  packed BCD result
//   cout       out  decimal carry-out (add) / borrow-out (subtract)
//   err        out  a captured digit of a or b was greater than 9
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// where valid and ready are both 1. in_ready and out_valid are decoded from
// the state register only, so neither has a combinational path from the
// opposite-direction input. The producer holds data stable while valid is
// high; sum/cout/err stay stable for the whole time out_valid is high.
//
// FSM state is held in `state_q` (type state_e) for debug visibility.
// -----------------------------------------------------------------------------
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;

  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;

  logic             accept;
  logic             last_digit;
  logic             sub_mode_in;

  // Digit slice signals
  logic [3:0]       a_dig;
  logic [3:0]       b_dig;
  logic [3:0]       bd;
  logic [4:0]       raw;
  logic [3:0]       dig_res;
  logic             carry_res;

`ifdef BCD_SUB_EN
  logic             sub_q, sub_d;
  assign sub_mode_in = sub;
`else
  // Subtraction is compiled out; the port stays for pin compatibility.
  logic             unused_sub;
  assign unused_sub  = sub;
  assign sub_mode_in = 1'b0;
`endif

  // Flags any digit of a packed BCD word that lies outside 0..9.
  function automatic logic any_bad_digit(input logic [W-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r = 1'b1;
    end
    return r;
  endfunction

  assign accept     = in_valid && (state_q == ST_IDLE);
  assign last_digit = (cnt_q == CNT_W'(DIGITS - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)   state_d = ST_CALC;
      ST_CALC: if (last_digit) state_d = ST_DONE;
      ST_DONE: if (out_ready)  state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded from registered state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    sum       = sum_q;
    cout      = cout_q;
    err       = err_q;
  end

  // ---------------------------------------------------------------------------
  // Single-digit decimal slice, steered by the digit counter
  // ---------------------------------------------------------------------------
  always_comb begin
    a_dig = a_q[{cnt_q, 2'b00} +: 4];
    b_dig = b_q[{cnt_q, 2'b00} +: 4];
`ifdef BCD_SUB_EN
    // 9's complement of B; wraps mod 16 so invalid digits stay deterministic.
    bd    = sub_q ? (4'd9 - b_dig) : b_dig;
`else
    bd    = b_dig;
`endif
    raw   = {1'b0, a_dig} + {1'b0, bd} + {4'b0000, carry_q};
    if (raw > 5'd9) begin
      // Adding 6 skips the six unused codes; truncation drops the decade.
      dig_res   = raw[3:0] + 4'd6;
      carry_res = 1'b1;
    end else begin
      dig_res   = raw[3:0];
      carry_res = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    err_d   = err_q;
`ifdef BCD_SUB_EN
    sub_d   = sub_q;
`endif

    if (accept) begin
      a_d     = a;
      b_d     = b;
      sum_d   = '0;
      cnt_d   = '0;
      cout_d  = 1'b0;
      err_d   = any_bad_digit(a) | any_bad_digit(b);
      // 10's complement subtract: A + (9's comp B) + 1, less the borrow-in.
      carry_d = sub_mode_in ? ~cin : cin;
`ifdef BCD_SUB_EN
      sub_d   = sub_mode_in;
`endif
    end else if (state_q == ST_CALC) begin
      sum_d[{cnt_q, 2'b00} +: 4] = dig_res;
      carry_d                    = carry_res;
      cnt_d                      = cnt_q + CNT_W'(1);
      if (last_digit) begin
`ifdef BCD_SUB_EN
        // No carry out of the top digit in subtract mode means a borrow.
        cout_d = sub_q ? ~carry_res : carry_res;
`else
        cout_d = carry_res;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef BCD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
`ifdef BCD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_bcd_serial_adder
//
// Directed self-checking bench for bcd_serial_adder with DIGITS=4.
// Expected values are hand-computed packed-BCD constants; subtraction
// expectations switch with BCD_SUB_EN so the bench fits either build.
// -----------------------------------------------------------------------------
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .err       (err)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change #1 after the rising edge, outputs sampled there)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for in_ready, then performs one input handshake.
  task automatic send(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                      input logic op_cin, input logic op_sub, input string tag);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a        = op_a;
    b        = op_b;
    cin      = op_cin;
    sub      = op_sub;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Checks that out_valid rises exactly DIGITS edges after acceptance.
  task automatic wait_result(input string tag);
    for (int i = 1; i < DIGITS; i++) tick();
    check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic check_result(input logic e_cout, input logic e_err, input string tag);
    logic [W-1:0] e_sum;
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e_sum = exp_q.pop_front();
      check({tag, "_sum"}, 32'(sum), 32'(e_sum));
    end
    check({tag, "_cout"}, 32'(cout), 32'(e_cout));
    check({tag, "_err"},  32'(err),  32'(e_err));
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready),  32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic op_cin, input logic op_sub,
                        input logic [W-1:0] e_sum, input logic e_cout,
                        input logic e_err, input string tag);
    exp_q.push_back(e_sum);
    send(op_a, op_b, op_cin, op_sub, tag);
    wait_result(tag);
    check_result(e_cout, e_err, tag);
    release_result(tag);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b0;

    // Reset values while held in reset
    #12;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_cout",      32'(cout),      32'd0);
    check("rst_err",       32'(err),       32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Plain add
    run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, "add");
    // Full carry ripple out of the top digit
    run_op(16'h9999, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple");
    // Mixed carries, no carry-in
    run_op(16'h4725, 16'h3896, 1'b0, 1'b0, 16'h8621, 1'b0, 1'b0, "add_mixed");

`ifdef BCD_SUB_EN
    run_op(16'h0500, 16'h0123, 1'b0, 1'b1, 16'h0377, 1'b0, 1'b0, "sub");
    run_op(16'h0123, 16'h0500, 1'b0, 1'b1, 16'h9623, 1'b1, 1'b0, "sub_neg");
    // Borrow-in: 0 - 0 - 1 = 9999 with borrow-out
    run_op(16'h0000, 16'h0000, 1'b1, 1'b1, 16'h9999, 1'b1, 1'b0, "sub_bin");
`else
    // sub ignored: always adds
    run_op(16'h0500, 16'h0123, 1'b0, 1'b1, 16'h0623, 1'b0, 1'b0, "sub_off");
    run_op(16'h0123, 16'h0500, 1'b0, 1'b1, 16'h0623, 1'b0, 1'b0, "sub_off_swap");
    run_op(16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, "sub_off_cin");
`endif

    // Invalid digit: flagged, arithmetic continues deterministically
    run_op(16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1, "invalid");
    // err recaptured on the next valid operation
    run_op(16'h0001, 16'h0008, 1'b0, 1'b0, 16'h0009, 1'b0, 1'b0, "err_clear");

    // out_ready held high while CALC runs: no effect until out_valid
    out_ready = 1'b1;
    exp_q.push_back(16'h0100);
    send(16'h0055, 16'h0045, 1'b0, 1'b0, "early_ready");
    wait_result("early_ready");
    check_result(1'b0, 1'b0, "early_ready");
    release_result("early_ready");

    // Backpressure: out_ready low for 5 cycles, stray in_valid ignored
    exp_q.push_back(16'h1998);
    send(16'h9999, 16'h1999, 1'b0, 1'b0, "bp");
    wait_result("bp");
    a        = 16'h1111;
    b        = 16'h2222;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_ready", 32'(in_ready),  32'd0);
      check("bp_hold_sum",   32'(sum),       32'h1998);
      check("bp_hold_cout",  32'(cout),      32'd1);
    end
    in_valid = 1'b0;
    check_result(1'b1, 1'b0, "bp");
    release_result("bp");
    run_op(16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, "bp_next");

    // Reset mid-operation, after two digits have been produced
    send(16'h00A9, 16'h0011, 1'b0, 1'b0, "mid_rst");
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check("mid_rst_sum",       32'(sum),       32'd0);
    check("mid_rst_cout",      32'(cout),      32'd0);
    check("mid_rst_err",       32'(err),       32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, "post_rst");

    // ---------------------------------------------------------------------------
    // Final report
    // ---------------------------------------------------------------------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
